// File: rtl/vec_test_seq.sv
// vec_test_seq: replays a table of {y_exp, b, a} vectors into a vector DUT and
// checks each result, either after a fixed latency or on a y_valid handshake.
// Reports sticky fail/finish, a saturating error count and the first failing step.
module vec_test_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned STEPS     = 16,
  parameter int unsigned LATENCY   = 0,
  parameter int unsigned HANDSHAKE = 0,
  parameter int unsigned TIMEOUT   = 64,
  parameter              STIM_FILE = "stim.hex",
  parameter              NAME      = "vec_test",
  // Table contents; entry i at [i*3*LANES*WIDTH +: 3*LANES*WIDTH]
  parameter logic [STEPS*3*LANES*WIDTH-1:0] STIM_TABLE = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [LANES*WIDTH-1:0] a,
  output logic [LANES*WIDTH-1:0] b,
  output logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] y,
  input  logic                   y_valid,
  output logic                   fail,
  output logic                   finish,
  output logic [15:0]            err_count,
  output logic [15:0]            first_fail
);

  localparam int unsigned V        = LANES * WIDTH;
  localparam int unsigned E        = 3 * V;
  localparam int unsigned IW       = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [15:0] LAST     = 16'(STEPS - 1);
  localparam logic [15:0] COUNT    = 16'(STEPS);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {ISSUE, DRAIN, DONE} state_t;

  state_t        state;
  logic [15:0]   issue_idx;
  logic [15:0]   chk_idx;
  logic [V-1:0]  exp_cur;
  logic [31:0]   tmo_cnt;
  logic [E-1:0]  stim_mem [STEPS];

  logic          pipe_v;
  logic [V-1:0]  pipe_exp;
  logic          cmp_en;
  logic [V-1:0]  cmp_exp;
  logic          mismatch;
  logic          last_chk;
  logic          overrun;
  logic          tmo_hit;
  logic [IW-1:0] chk_sel;
  logic [IW-1:0] next_sel;
  logic [E-1:0]  chk_entry;

  for (genvar i = 0; i < STEPS; i++) begin : g_entry
    assign stim_mem[i] = STIM_TABLE[i*E +: E];
  end

  if (LATENCY == 0) begin : g_lat0
    assign pipe_v   = in_valid;
    assign pipe_exp = exp_cur;
  end else begin : g_lat
    logic         dv [LATENCY];
    logic [V-1:0] de [LATENCY];

    // Delay line carrying each issued step's valid bit and expected vector
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int unsigned i = 0; i < LATENCY; i++) dv[i] <= 1'b0;
      end else if (state != DONE) begin
        dv[0] <= in_valid;
        de[0] <= exp_cur;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          dv[i] <= dv[i-1];
          de[i] <= de[i-1];
        end
      end
    end

    assign pipe_v   = dv[LATENCY-1];
    assign pipe_exp = de[LATENCY-1];
  end

  // Select what is compared this cycle and detect mismatch/overrun/timeout
  always_comb begin
    chk_sel   = (chk_idx < COUNT) ? chk_idx[IW-1:0] : '0;
    next_sel  = issue_idx[IW-1:0] + 1'b1;
    chk_entry = stim_mem[chk_sel];
    if (HANDSHAKE != 0) begin
      cmp_en  = y_valid && (chk_idx < COUNT);
      cmp_exp = chk_entry[E-1 -: V];
    end else begin
      cmp_en  = pipe_v;
      cmp_exp = pipe_exp;
    end
    cmp_en   = cmp_en && (state != DONE);
    mismatch = (y != cmp_exp);
    last_chk = (chk_idx == LAST);
    overrun  = (HANDSHAKE != 0) && y_valid && (chk_idx == COUNT);
    tmo_hit  = (HANDSHAKE != 0) && (state != DONE) && !y_valid &&
               (chk_idx < COUNT) && (tmo_cnt == TMO_LAST);
  end

  // Sequencer state, stimulus registers and sticky result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= ISSUE;
      issue_idx             <= '0;
      chk_idx               <= '0;
      tmo_cnt               <= '0;
      {exp_cur, b, a}       <= stim_mem[0];
      in_valid              <= 1'b1;
      fail                  <= 1'b0;
      finish                <= 1'b0;
      err_count             <= '0;
      first_fail            <= '1;
    end else begin
      if (overrun) fail <= 1'b1;
      if (state != DONE) begin
        if (state == ISSUE) begin
          if (issue_idx == LAST) begin
            state    <= DRAIN;
            in_valid <= 1'b0;
          end else begin
            issue_idx       <= issue_idx + 16'd1;
            {exp_cur, b, a} <= stim_mem[next_sel];
          end
        end
        if (HANDSHAKE != 0) begin
          if (y_valid)             tmo_cnt <= '0;
          else if (chk_idx < COUNT) tmo_cnt <= tmo_cnt + 32'd1;
        end
        // Completion can land on the last ISSUE edge (zero latency or fast DUT),
        // so DONE overrides the ISSUE->DRAIN move made above.
        if (cmp_en) begin
          chk_idx <= chk_idx + 16'd1;
          if (mismatch) begin
            fail <= 1'b1;
            if (err_count != 16'hFFFF)  err_count  <= err_count + 16'd1;
            if (first_fail == 16'hFFFF) first_fail <= chk_idx;
          end
          if (last_chk) begin
            finish <= 1'b1;
            state  <= DONE;
          end
        end
        if (tmo_hit) begin
          fail   <= 1'b1;
          finish <= 1'b1;
          state  <= DONE;
        end
      end
    end
  end

`ifndef SYNTHESIS
  function automatic string lanes_str(input logic [V-1:0] v);
    string s;
    s = "";
    for (int unsigned i = 0; i < LANES; i++)
      s = {s, $sformatf(" %0d", $signed(v[i*WIDTH +: WIDTH]))};
    return s;
  endfunction

  // Simulation message for each differing step, signed lanes with lane 0 first
  always_ff @(posedge clock) begin
    if (!reset && cmp_en && mismatch)
      $display("%s: step %0d differs: y=[%s ] exp=[%s ]",
               NAME, chk_idx, lanes_str(y), lanes_str(cmp_exp));
  end
`endif

endmodule

// File: tb/tb_vec_test_seq.sv
// tb_vec_test_seq: directed checks of vec_test_seq in fixed-latency,
// pipelined, handshake, timeout, overrun and mid-run reset scenarios.
module tb_vec_test_seq;

  // Steps 0..3 of an i8 x4 add table, each entry {y_exp, b, a}, lane 0 in LSBs
  localparam logic [383:0] T4 = {
    32'h0100FFFE, 32'h020100FF, 32'hFFFFFFFF,
    32'h09080706, 32'h01010101, 32'h08070605,
    32'h001E7F80, 32'h0014FF01, 32'h000A807F,
    32'h020205FD, 32'h01000301, 32'h010202FC};
  // Same table with step 2 lane 1 expected value corrupted (7 -> 0x17)
  localparam logic [383:0] T4_BAD = {
    32'h0100FFFE, 32'h020100FF, 32'hFFFFFFFF,
    32'h09081706, 32'h01010101, 32'h08070605,
    32'h001E7F80, 32'h0014FF01, 32'h000A807F,
    32'h020205FD, 32'h01000301, 32'h010202FC};
  localparam logic [767:0] T8 = {T4, T4};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [31:0] y_tab [4] = '{32'h020205FD, 32'h001E7F80, 32'h09080706, 32'h0100FFFE};

  logic [31:0] pass_a, pass_b, pass_y;  logic pass_iv, pass_fail, pass_fin; logic [15:0] pass_err, pass_ff;
  logic [31:0] mis_a,  mis_b,  mis_y;   logic mis_iv,  mis_fail,  mis_fin;  logic [15:0] mis_err,  mis_ff;
  logic [31:0] pipe_a, pipe_b, pipe_y;  logic pipe_iv, pipe_fail, pipe_fin; logic [15:0] pipe_err, pipe_ff;
  logic [31:0] hs_a,   hs_b,   hs_y;    logic hs_iv,   hs_fail,   hs_fin;   logic [15:0] hs_err,   hs_ff;
  logic [31:0] tmo_a,  tmo_b;           logic tmo_iv,  tmo_fail,  tmo_fin;  logic [15:0] tmo_err,  tmo_ff;
  logic [31:0] ovr_a,  ovr_b,  ovr_y;   logic ovr_iv,  ovr_fail,  ovr_fin;  logic [15:0] ovr_err,  ovr_ff;
  logic hs_yv, ovr_yv;
  logic [31:0] pipe_r1;

  function automatic logic [31:0] add4(input logic [31:0] x, input logic [31:0] z);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = x[i*8 +: 8] + z[i*8 +: 8];
    return r;
  endfunction

  // Combinational adder DUTs and a two-stage registered adder DUT
  always_comb begin
    pass_y = add4(pass_a, pass_b);
    mis_y  = add4(mis_a, mis_b);
  end

  always @(posedge clock) begin
    if (reset) begin
      pipe_r1 <= '0;
      pipe_y  <= '0;
    end else begin
      pipe_r1 <= add4(pipe_a, pipe_b);
      pipe_y  <= pipe_r1;
    end
  end

  vec_test_seq #(.WIDTH(8), .LANES(4), .STEPS(4), .LATENCY(0), .HANDSHAKE(0), .TIMEOUT(64),
                 .STIM_FILE(""), .NAME("pass"), .STIM_TABLE(T4)) u_pass (
    .clock(clock), .reset(reset), .a(pass_a), .b(pass_b), .in_valid(pass_iv),
    .y(pass_y), .y_valid(1'b0), .fail(pass_fail), .finish(pass_fin),
    .err_count(pass_err), .first_fail(pass_ff));

  vec_test_seq #(.WIDTH(8), .LANES(4), .STEPS(4), .LATENCY(0), .HANDSHAKE(0), .TIMEOUT(64),
                 .STIM_FILE(""), .NAME("mis"), .STIM_TABLE(T4_BAD)) u_mis (
    .clock(clock), .reset(reset), .a(mis_a), .b(mis_b), .in_valid(mis_iv),
    .y(mis_y), .y_valid(1'b0), .fail(mis_fail), .finish(mis_fin),
    .err_count(mis_err), .first_fail(mis_ff));

  vec_test_seq #(.WIDTH(8), .LANES(4), .STEPS(8), .LATENCY(2), .HANDSHAKE(0), .TIMEOUT(64),
                 .STIM_FILE(""), .NAME("pipe"), .STIM_TABLE(T8)) u_pipe (
    .clock(clock), .reset(reset), .a(pipe_a), .b(pipe_b), .in_valid(pipe_iv),
    .y(pipe_y), .y_valid(1'b0), .fail(pipe_fail), .finish(pipe_fin),
    .err_count(pipe_err), .first_fail(pipe_ff));

  vec_test_seq #(.WIDTH(8), .LANES(4), .STEPS(4), .LATENCY(0), .HANDSHAKE(1), .TIMEOUT(5),
                 .STIM_FILE(""), .NAME("hs"), .STIM_TABLE(T4)) u_hs (
    .clock(clock), .reset(reset), .a(hs_a), .b(hs_b), .in_valid(hs_iv),
    .y(hs_y), .y_valid(hs_yv), .fail(hs_fail), .finish(hs_fin),
    .err_count(hs_err), .first_fail(hs_ff));

  vec_test_seq #(.WIDTH(8), .LANES(4), .STEPS(4), .LATENCY(0), .HANDSHAKE(1), .TIMEOUT(5),
                 .STIM_FILE(""), .NAME("tmo"), .STIM_TABLE(T4)) u_tmo (
    .clock(clock), .reset(reset), .a(tmo_a), .b(tmo_b), .in_valid(tmo_iv),
    .y(32'h0), .y_valid(1'b0), .fail(tmo_fail), .finish(tmo_fin),
    .err_count(tmo_err), .first_fail(tmo_ff));

  vec_test_seq #(.WIDTH(8), .LANES(4), .STEPS(4), .LATENCY(0), .HANDSHAKE(1), .TIMEOUT(64),
                 .STIM_FILE(""), .NAME("ovr"), .STIM_TABLE(T4)) u_ovr (
    .clock(clock), .reset(reset), .a(ovr_a), .b(ovr_b), .in_valid(ovr_iv),
    .y(ovr_y), .y_valid(ovr_yv), .fail(ovr_fail), .finish(ovr_fin),
    .err_count(ovr_err), .first_fail(ovr_ff));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    hs_yv = 1'b0; hs_y = '0; ovr_yv = 1'b0; ovr_y = '0;
    tick(); tick();
    reset = 1'b0;
    // cycle 0: reset state
    check("pass.a_c0", pass_a, 32'h010202FC);
    check("pass.b_c0", pass_b, 32'h01000301);
    check("pass.iv_c0", pass_iv, 1);
    check("pass.fail_c0", pass_fail, 0);
    check("pass.fin_c0", pass_fin, 0);
    check("pass.err_c0", pass_err, 0);
    check("pass.ff_c0", pass_ff, 32'hFFFF);
    ovr_yv = 1'b1; ovr_y = y_tab[0];
    tick(); // cycle 1
    check("pass.a_c1", pass_a, 32'h000A807F);
    check("pass.b_c1", pass_b, 32'h0014FF01);
    ovr_y = y_tab[1];
    tick(); // cycle 2
    check("mis.fail_c2", mis_fail, 0);
    check("pipe.fail_c2", pipe_fail, 0);
    ovr_y = y_tab[2];
    tick(); // cycle 3
    check("mis.fail_c3", mis_fail, 1);
    check("mis.err_c3", mis_err, 1);
    check("mis.ff_c3", mis_ff, 2);
    check("mis.fin_c3", mis_fin, 0);
    check("pass.a_c3", pass_a, 32'hFFFFFFFF);
    check("pass.iv_c3", pass_iv, 1);
    check("pass.fin_c3", pass_fin, 0);
    hs_yv = 1'b1; hs_y = y_tab[0]; ovr_y = y_tab[3];
    tick(); // cycle 4
    check("pass.fin_c4", pass_fin, 1);
    check("pass.fail_c4", pass_fail, 0);
    check("pass.err_c4", pass_err, 0);
    check("pass.ff_c4", pass_ff, 32'hFFFF);
    check("pass.iv_c4", pass_iv, 0);
    check("pass.a_c4", pass_a, 32'hFFFFFFFF);
    check("mis.fin_c4", mis_fin, 1);
    check("mis.err_c4", mis_err, 1);
    check("ovr.fin_c4", ovr_fin, 1);
    check("ovr.fail_c4", ovr_fail, 0);
    check("tmo.fail_c4", tmo_fail, 0);
    check("tmo.fin_c4", tmo_fin, 0);
    hs_yv = 1'b0; ovr_yv = 1'b0;
    tick(); // cycle 5
    check("tmo.fail_c5", tmo_fail, 1);
    check("tmo.fin_c5", tmo_fin, 1);
    check("ovr.fail_c5", ovr_fail, 0);
    ovr_yv = 1'b1;
    tick(); // cycle 6
    check("ovr.fail_c6", ovr_fail, 1);
    check("ovr.err_c6", ovr_err, 0);
    check("ovr.ff_c6", ovr_ff, 32'hFFFF);
    ovr_yv = 1'b0;
    tick(); // cycle 7
    hs_yv = 1'b1; hs_y = y_tab[1];
    tick(); // cycle 8
    hs_yv = 1'b0;
    tick(); // cycle 9
    check("pipe.fin_c9", pipe_fin, 0);
    tick(); // cycle 10
    check("pipe.fin_c10", pipe_fin, 1);
    check("pipe.fail_c10", pipe_fail, 0);
    check("pipe.err_c10", pipe_err, 0);
    tick(); // cycle 11
    hs_yv = 1'b1; hs_y = y_tab[2];
    tick(); // cycle 12
    hs_yv = 1'b0;
    tick(); tick(); tick(); // cycle 15
    check("hs.fin_c15", hs_fin, 0);
    hs_yv = 1'b1; hs_y = y_tab[3];
    tick(); // cycle 16
    hs_yv = 1'b0;
    check("hs.fin_c16", hs_fin, 1);
    check("hs.fail_c16", hs_fail, 0);
    check("hs.err_c16", hs_err, 0);
    check("pass.a_c16", pass_a, 32'hFFFFFFFF);

    // Reset after a failing run restores every reset value
    reset = 1'b1;
    tick();
    check("mis.fail_rst", mis_fail, 0);
    check("mis.fin_rst", mis_fin, 0);
    check("mis.err_rst", mis_err, 0);
    check("mis.ff_rst", mis_ff, 32'hFFFF);
    check("mis.a_rst", mis_a, 32'h010202FC);
    check("mis.iv_rst", mis_iv, 1);
    reset = 1'b0;
    tick(); tick(); // cycle 2 of the rerun: pulse reset before step 2 is judged
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mis.fail_r0", mis_fail, 0);
    check("mis.a_r0", mis_a, 32'h010202FC);
    tick(); tick(); tick(); // cycle 3
    check("mis.fail_r3", mis_fail, 1);
    check("mis.fin_r3", mis_fin, 0);
    check("pipe.fail_r3", pipe_fail, 0);
    tick(); // cycle 4
    check("mis.fin_r4", mis_fin, 1);
    check("pass.fin_r4", pass_fin, 1);
    tick(); tick(); tick(); tick(); tick(); // cycle 9
    check("pipe.fin_r9", pipe_fin, 0);
    tick(); // cycle 10
    check("pipe.fin_r10", pipe_fin, 1);
    check("pipe.fail_r10", pipe_fail, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
